// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the ID/EX operand stage
package pipe_pkg;

  localparam int CTRL_W      = 12;
  localparam int MEMREAD_BIT = 3;
  localparam int STALL_W     = 16;

  typedef logic [4:0] regidx_t;

  typedef struct packed {
    logic [31:0]       a;
    logic [31:0]       b;
    regidx_t           rs;
    regidx_t           rt;
    regidx_t           rd;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       imm;
  } idex_t;

  // A source only conflicts with a destination when the instruction actually reads it
  function automatic logic src_hit(input logic uses, input regidx_t idx, input regidx_t rd);
    return uses && (idx == rd);
  endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// rtl/wb_bypass_mux.sv - zero-aware select between register-file data and a same-cycle WB write
module wb_bypass_mux
  import pipe_pkg::*;
(
  input  logic [4:0]  idx,
  input  logic [31:0] rf_data,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rw,
  input  logic [31:0] wb_wd,
  output logic [31:0] data
);

  // r0 reads as zero; a WB write to the same index wins over the stale register-file value
  always_comb begin
    data = rf_data;
    if (idx == 5'd0) begin
      data = 32'd0;
    end else if (wb_regwrite && (wb_rw == idx)) begin
      data = wb_wd;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with WB bypass, load-use bubble and elastic handshake
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W      = pipe_pkg::CTRL_W,
  parameter int MEMREAD_BIT = pipe_pkg::MEMREAD_BIT,
  parameter int STALL_W     = pipe_pkg::STALL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_rs,
  input  logic [4:0]         in_rt,
  input  logic [4:0]         in_rd,
  input  logic               in_uses_rs,
  input  logic               in_uses_rt,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [31:0]        in_imm,
  output logic [4:0]         rf_r1,
  output logic [4:0]         rf_r2,
  input  logic [31:0]        rf_d1,
  input  logic [31:0]        rf_d2,
  input  logic               wb_regwrite,
  input  logic [4:0]         wb_rw,
  input  logic [31:0]        wb_wd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_a,
  output logic [31:0]        out_b,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_rd,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [31:0]        out_imm,
  output logic [STALL_W-1:0] stall_cnt
);

  idex_t       idex;
  logic        valid_q;
  logic [31:0] cap_a;
  logic [31:0] cap_b;
  logic [31:0] held_a;
  logic [31:0] held_b;
  logic        haz;
  logic        adv;

  assign rf_r1 = in_rs;
  assign rf_r2 = in_rt;

  // Operands for a fresh capture: register file, overridden by a write landing this edge
  wb_bypass_mux u_cap_a (
    .idx         (in_rs),
    .rf_data     (rf_d1),
    .wb_regwrite (wb_regwrite),
    .wb_rw       (wb_rw),
    .wb_wd       (wb_wd),
    .data        (cap_a)
  );

  wb_bypass_mux u_cap_b (
    .idx         (in_rt),
    .rf_data     (rf_d2),
    .wb_regwrite (wb_regwrite),
    .wb_rw       (wb_rw),
    .wb_wd       (wb_wd),
    .data        (cap_b)
  );

  // Operands for a held entry: keep the captured value unless WB rewrites that register
  wb_bypass_mux u_hold_a (
    .idx         (idex.rs),
    .rf_data     (idex.a),
    .wb_regwrite (wb_regwrite),
    .wb_rw       (wb_rw),
    .wb_wd       (wb_wd),
    .data        (held_a)
  );

  wb_bypass_mux u_hold_b (
    .idx         (idex.rt),
    .rf_data     (idex.b),
    .wb_regwrite (wb_regwrite),
    .wb_rw       (wb_rw),
    .wb_wd       (wb_wd),
    .data        (held_b)
  );

  assign haz = valid_q && idex.ctrl[MEMREAD_BIT] && (idex.rd != 5'd0) &&
               (src_hit(in_uses_rs, in_rs, idex.rd) || src_hit(in_uses_rt, in_rt, idex.rd));
  assign adv      = !valid_q || out_ready;
  assign in_ready = adv && !haz && !flush;

  // ID/EX register update: flush, then load-use bubble, then load/drain, else hold with refresh
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex      <= '0;
      valid_q   <= 1'b0;
      stall_cnt <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      idex.ctrl <= '0;
    end else if (adv && haz) begin
      valid_q   <= 1'b0;
      idex.ctrl <= '0;
      if (in_valid && (stall_cnt != {STALL_W{1'b1}})) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end else if (adv && in_valid) begin
      valid_q   <= 1'b1;
      idex.a    <= cap_a;
      idex.b    <= cap_b;
      idex.rs   <= in_rs;
      idex.rt   <= in_rt;
      idex.rd   <= in_rd;
      idex.ctrl <= in_ctrl;
      idex.imm  <= in_imm;
    end else if (adv) begin
      valid_q <= 1'b0;
    end else begin
      idex.a <= held_a;
      idex.b <= held_b;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = idex.a;
  assign out_b     = idex.b;
  assign out_rs    = idex.rs;
  assign out_rt    = idex.rt;
  assign out_rd    = idex.rd;
  assign out_ctrl  = idex.ctrl;
  assign out_imm   = idex.imm;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_uses_rs, in_uses_rt;
  logic [11:0] in_ctrl;
  logic [31:0] in_imm;
  logic [31:0] rf_d1, rf_d2;
  logic        wb_regwrite;
  logic [4:0]  wb_rw;
  logic [31:0] wb_wd;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [4:0]  rf_r1, rf_r2, out_rs, out_rt, out_rd;
  logic [31:0] out_a, out_b, out_imm;
  logic [11:0] out_ctrl;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [4:0]  s_rf_r1, s_rf_r2, s_out_rs, s_out_rt, s_out_rd;
  logic [31:0] s_out_a, s_out_b, s_out_imm;
  logic [11:0] s_out_ctrl;
  logic [2:0]  s_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt),
    .in_ctrl(in_ctrl), .in_imm(in_imm), .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_d1(rf_d1), .rf_d2(rf_d2),
    .wb_regwrite(wb_regwrite), .wb_rw(wb_rw), .wb_wd(wb_wd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_ctrl(out_ctrl), .out_imm(out_imm),
    .stall_cnt(stall_cnt)
  );

  // Narrow stall counter so saturation is reachable in a few cycles
  id_ex_operand_stage #(.STALL_W(3)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt),
    .in_ctrl(in_ctrl), .in_imm(in_imm), .rf_r1(s_rf_r1), .rf_r2(s_rf_r2), .rf_d1(rf_d1), .rf_d2(rf_d2),
    .wb_regwrite(wb_regwrite), .wb_rw(wb_rw), .wb_wd(wb_wd), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_a(s_out_a), .out_b(s_out_b),
    .out_rs(s_out_rs), .out_rt(s_out_rt), .out_rd(s_out_rd), .out_ctrl(s_out_ctrl), .out_imm(s_out_imm),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic urs, input logic urt, input logic [11:0] ctrl, input logic [31:0] imm,
                       input logic [31:0] d1, input logic [31:0] d2);
    in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd; in_uses_rs = urs; in_uses_rt = urt;
    in_ctrl = ctrl; in_imm = imm; rf_d1 = d1; rf_d2 = d2;
  endtask

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [11:0] ctrl;
    logic [31:0] imm, d1, d2;
    logic        wbe;
    logic [4:0]  wrw;
    logic [31:0] wwd;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, rd;
    logic [11:0] ctrl;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];

  task automatic sb_check(input string tag);
    exp_t e;
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " out_a"}, out_a, e.a);
      check({tag, " out_b"}, out_b, e.b);
      check({tag, " out_rs"}, {27'd0, out_rs}, {27'd0, e.rs});
      check({tag, " out_rt"}, {27'd0, out_rt}, {27'd0, e.rt});
      check({tag, " out_rd"}, {27'd0, out_rd}, {27'd0, e.rd});
      check({tag, " out_ctrl"}, {20'd0, out_ctrl}, {20'd0, e.ctrl});
      check({tag, " out_imm"}, out_imm, e.imm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5'd5,  5'd6,  5'd1,  12'h001, 32'h10,  32'h11,       32'h22,       1'b1, 5'd5,  32'hAB,       32'hAB,       32'h22};
    vecs[1] = '{5'd0,  5'd3,  5'd2,  12'h0F0, 32'h20,  32'h99,       32'h33,       1'b1, 5'd0,  32'hCD,       32'h0,        32'h33};
    vecs[2] = '{5'd4,  5'd4,  5'd3,  12'h105, 32'h30,  32'h44,       32'h45,       1'b1, 5'd4,  32'h1234,     32'h1234,     32'h1234};
    vecs[3] = '{5'd8,  5'd9,  5'd12, 12'h802, 32'h40,  32'h80,       32'h90,       1'b0, 5'd8,  32'hFF,       32'h80,       32'h90};
    vecs[4] = '{5'd10, 5'd0,  5'd13, 12'h010, 32'h50,  32'hA0,       32'hB0,       1'b1, 5'd11, 32'h77,       32'hA0,       32'h0};
    vecs[5] = '{5'd31, 5'd30, 5'd14, 12'hA00, 32'h60,  32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 5'd30, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h5A5A5A5A};

    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_regwrite = 1'b0; wb_rw = 5'd0; wb_wd = 32'd0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
    #3;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_a", out_a, 32'd0);
    check("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
    tick();
    rst = 1'b1;

    // Table-driven captures, including same-cycle WB bypass and r0 handling
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].rs, vecs[i].rt, vecs[i].rd, 1'b1, 1'b1, vecs[i].ctrl, vecs[i].imm, vecs[i].d1, vecs[i].d2);
      wb_regwrite = vecs[i].wbe; wb_rw = vecs[i].wrw; wb_wd = vecs[i].wwd;
      sb_q.push_back('{vecs[i].exp_a, vecs[i].exp_b, vecs[i].imm, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].ctrl});
      #1;
      check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      check($sformatf("vec%0d rf_r1", i), {27'd0, rf_r1}, {27'd0, vecs[i].rs});
      tick();
      sb_check($sformatf("vec%0d", i));
    end

    // Asynchronous reset while an entry is valid
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
    wb_regwrite = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst out_a", out_a, 32'd0);
    check("midrst out_ctrl", {20'd0, out_ctrl}, 32'd0);
    check("midrst out_imm", out_imm, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("post-reset in_ready", {31'd0, in_ready}, 32'd1);

    // Load-use: lw r7 followed by add reading r7
    drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 12'h008, 32'h4, 32'h100, 32'h0);
    tick();
    check("lw out_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b1, 12'h001, 32'h0, 32'h700, 32'h200);
    #1;
    check("loaduse in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("bubble out_valid", {31'd0, out_valid}, 32'd0);
    check("bubble out_ctrl", {20'd0, out_ctrl}, 32'd0);
    check("bubble stall_cnt", {16'd0, stall_cnt}, 32'd1);
    check("after bubble in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.push_back('{32'h700, 32'h200, 32'h0, 5'd7, 5'd2, 5'd8, 12'h001});
    tick();
    sb_check("add issue");
    check("add stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Held entry refreshed by WB while EX back-pressures
    drive(1'b1, 5'd3, 5'd9, 5'd10, 1'b1, 1'b1, 12'h020, 32'h42, 32'h333, 32'h999);
    tick();
    check("held load out_b", out_b, 32'h999);
    out_ready = 1'b0;
    drive(1'b1, 5'd4, 5'd5, 5'd11, 1'b1, 1'b1, 12'h002, 32'h77, 32'h444, 32'h555);
    wb_regwrite = 1'b1; wb_rw = 5'd9; wb_wd = 32'h5555;
    #1;
    check("held in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    sb_q.push_back('{32'h333, 32'h5555, 32'h42, 5'd3, 5'd9, 5'd10, 12'h020});
    sb_check("held refresh");
    wb_regwrite = 1'b0;
    out_ready = 1'b1;
    sb_q.push_back('{32'h444, 32'h555, 32'h77, 5'd4, 5'd5, 5'd11, 12'h002});
    tick();
    sb_check("after hold");

    // Flush kills the ID/EX entry and does not consume IF/ID
    drive(1'b1, 5'd12, 5'd13, 5'd6, 1'b1, 1'b1, 12'h080, 32'h99, 32'h1200, 32'h1300);
    flush = 1'b1;
    #1;
    check("flush in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    check("flush out_ctrl", {20'd0, out_ctrl}, 32'd0);
    flush = 1'b0;
    sb_q.push_back('{32'h1200, 32'h1300, 32'h99, 5'd12, 5'd13, 5'd6, 12'h080});
    tick();
    sb_check("post-flush reissue");

    // Back-to-back load-use hazards drive the counters toward saturation
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 12'h008, 32'h0, 32'h70, 32'h0);
    for (int i = 0; i < 12; i++) tick();
    check("six hazards stall_cnt", {16'd0, stall_cnt}, 32'd7);
    check("narrow at max", {29'd0, s_stall_cnt}, 32'd7);
    for (int i = 0; i < 6; i++) tick();
    check("nine hazards stall_cnt", {16'd0, stall_cnt}, 32'd10);
    check("narrow saturated", {29'd0, s_stall_cnt}, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
